// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with selectable registered / first-word-fall-through read,
// occupancy count, threshold flags, overflow/underflow pulses and sync flush.
module sync_fifo_ext #(
  parameter int DEPTH     = 8,
  parameter int DWIDTH    = 16,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DWIDTH-1:0]        din,
  input  logic                     rd_en,
  output logic [DWIDTH-1:0]        dout,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_empty,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic              rd_acc, wr_acc;

  assign empty        = (count == CW'(0));
  assign full         = (count == CW'(DEPTH));
  assign almost_empty = (count <= CW'(AE_THRESH));
  assign almost_full  = (count >= CW'(AF_THRESH));

  // A write into a full FIFO is only taken when a read frees the slot the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + AW'(1);
      if (rd_acc) rptr <= rptr + AW'(1);
      count     <= count + CW'(wr_acc) - CW'(rd_acc);
      overflow  <= wr_en && !wr_acc;
      underflow <= rd_en && !rd_acc;
    end
  end

  // Storage is never cleared; only pointers and count define valid data.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_acc) mem[wptr] <= din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout = mem[rptr];
    end else begin : g_reg
      always_ff @(posedge clk) begin
        if (rst)                   dout <= '0;
        else if (!flush && rd_acc) dout <= mem[rptr];
      end
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: a registered-read and an FWFT instance share stimulus
// and are checked against a queue-based reference model.
module tb_sync_fifo_ext;
  localparam int DEPTH = 8;

  logic        clk = 0;
  logic        rst = 0, flush = 0, wr_en = 0, rd_en = 0;
  logic [15:0] din = '0;
  logic [15:0] dout0, dout1;
  logic        e0, f0, ae0, af0, ov0, un0;
  logic        e1, f1, ae1, af1, ov1, un1;
  logic [3:0]  cnt0, cnt1;

  int total = 0, bad = 0;

  // reference model
  logic [15:0] q[$];
  logic [15:0] m_dout0 = '0;
  logic        m_ov = 0, m_un = 0;

  always #5 clk = ~clk;

  sync_fifo_ext #(.DEPTH(8), .DWIDTH(16), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout0), .empty(e0), .full(f0), .almost_empty(ae0), .almost_full(af0),
    .count(cnt0), .overflow(ov0), .underflow(un0));

  sync_fifo_ext #(.DEPTH(8), .DWIDTH(16), .FWFT(1), .AF_THRESH(6), .AE_THRESH(1)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout1), .empty(e1), .full(f1), .almost_empty(ae1), .almost_full(af1),
    .count(cnt1), .overflow(ov1), .underflow(un1));

  // Drive one cycle, advance the model on the edge, leave time at edge+1.
  task automatic step(input logic w, input logic r, input logic [15:0] d,
                      input logic fl = 1'b0, input logic rs = 1'b0);
    bit ra, wa;
    wr_en = w; rd_en = r; din = d; flush = fl; rst = rs;
    @(posedge clk);
    if (rs) begin
      q.delete(); m_dout0 = '0; m_ov = 0; m_un = 0;
    end else if (fl) begin
      q.delete(); m_ov = 0; m_un = 0;
    end else begin
      ra = r && (q.size() > 0);
      wa = w && ((q.size() < DEPTH) || ra);
      if (ra) m_dout0 = q.pop_front();
      if (wa) q.push_back(d);
      m_ov = w && !wa;
      m_un = r && !ra;
    end
    #1;
    wr_en = 0; rd_en = 0; flush = 0; rst = 0;
  endtask

  task automatic test_reset();
    step(0, 0, 16'h0, 0, 1);
    step(0, 0, 16'h0, 0, 1);
    total++; if ({cnt0, e0, f0, ae0, af0, ov0, un0} !== {4'd0, 6'b101000}) begin
      bad++; $display("FAIL reset_state: got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b, want 0 1 0 1 0 0 0",
                      cnt0, e0, f0, ae0, af0, ov0, un0); end
    total++; if (dout0 !== 16'h0) begin
      bad++; $display("FAIL reset_dout: got %h want 0000", dout0); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 16'(i));
      total++; if (cnt0 !== 4'(i) || af0 !== (i >= 6) || full_exp_mismatch(i)) begin
        bad++; $display("FAIL fill_%0d: got cnt=%0d af=%b f=%b, want cnt=%0d af=%b f=%b",
                        i, cnt0, af0, f0, i, (i >= 6), (i == 8)); end
    end
    step(1, 0, 16'h0009);
    total++; if (ov0 !== 1'b1 || cnt0 !== 4'd8) begin
      bad++; $display("FAIL overflow_pulse: got ov=%b cnt=%0d want ov=1 cnt=8", ov0, cnt0); end
    step(0, 0, 16'h0);
    total++; if (ov0 !== 1'b0) begin
      bad++; $display("FAIL overflow_one_cycle: got ov=%b want 0", ov0); end
  endtask

  function automatic bit full_exp_mismatch(input int i);
    return (f0 !== (i == 8));
  endfunction

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      total++; if (dout1 !== 16'(i)) begin
        bad++; $display("FAIL fwft_head_%0d: got %h want %h", i, dout1, 16'(i)); end
      step(0, 1, 16'h0);
      total++; if (dout0 !== 16'(i)) begin
        bad++; $display("FAIL drain_%0d: got %h want %h", i, dout0, 16'(i)); end
    end
    step(0, 1, 16'h0);
    total++; if (un0 !== 1'b1 || dout0 !== 16'h0008 || e0 !== 1'b1) begin
      bad++; $display("FAIL underflow_pulse: got un=%b dout=%h e=%b want 1 0008 1", un0, dout0, e0); end
    step(0, 0, 16'h0);
    total++; if (un0 !== 1'b0) begin
      bad++; $display("FAIL underflow_one_cycle: got un=%b want 0", un0); end
  endtask

  task automatic test_pass_through();
    logic [15:0] want;
    for (int i = 1; i <= 8; i++) step(1, 0, 16'h0100 + 16'(i));
    step(1, 1, 16'hAAAA);
    total++; if (cnt0 !== 4'd8 || ov0 !== 1'b0 || dout0 !== 16'h0101) begin
      bad++; $display("FAIL full_rw: got cnt=%0d ov=%b dout=%h want 8 0 0101", cnt0, ov0, dout0); end
    for (int i = 2; i <= 9; i++) begin
      step(0, 1, 16'h0);
      want = (i == 9) ? 16'hAAAA : 16'h0100 + 16'(i);
      total++; if (dout0 !== want) begin
        bad++; $display("FAIL pass_order_%0d: got %h want %h", i, dout0, want); end
    end
  endtask

  task automatic test_random();
    int nw = 0;
    for (int c = 0; c < 160; c++) begin
      logic w, r;
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 50);
      if (w) nw++;
      step(w, r, 16'($urandom));
      total++;
      if (cnt0 !== 4'(q.size()) || cnt1 !== 4'(q.size()) || e0 !== (q.size() == 0) ||
          f0 !== (q.size() == DEPTH) || ae0 !== (q.size() <= 1) || af0 !== (q.size() >= 6) ||
          ov0 !== m_ov || un0 !== m_un || ov1 !== m_ov || un1 !== m_un || dout0 !== m_dout0 ||
          e1 !== e0 || f1 !== f0 || ae1 !== ae0 || af1 !== af0 ||
          (q.size() > 0 && dout1 !== q[0])) begin
        bad++;
        $display("FAIL random_c%0d: got cnt=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b d0=%h d1=%h, want cnt=%0d ov=%b un=%b d0=%h",
                 c, cnt0, e0, f0, ae0, af0, ov0, un0, dout0, dout1, q.size(), m_ov, m_un, m_dout0);
      end
    end
    total++; if (nw < 40) begin
      bad++; $display("FAIL random_writes: got %0d want >=40", nw); end
  endtask

  task automatic test_fwft();
    step(0, 0, 16'h0, 1);
    step(1, 0, 16'h1234);
    total++; if (e1 !== 1'b0 || dout1 !== 16'h1234) begin
      bad++; $display("FAIL fwft_first: got e=%b dout=%h want 0 1234", e1, dout1); end
    step(0, 1, 16'h0);
    total++; if (e1 !== 1'b1 || un1 !== 1'b0) begin
      bad++; $display("FAIL fwft_pop: got e=%b un=%b want 1 0", e1, un1); end
  endtask

  task automatic test_flush_reset();
    logic [15:0] held;
    for (int i = 0; i < 5; i++) step(1, 0, 16'h0C00 + 16'(i));
    step(0, 1, 16'h0);
    held = m_dout0;
    step(1, 0, 16'hDEAD, 1);
    total++; if (cnt0 !== 4'd0 || e0 !== 1'b1 || ov0 !== 1'b0 || un0 !== 1'b0 || dout0 !== held) begin
      bad++; $display("FAIL flush: got cnt=%0d e=%b ov=%b un=%b dout=%h want 0 1 0 0 %h",
                      cnt0, e0, ov0, un0, dout0, held); end
    step(0, 0, 16'h0);
    total++; if (cnt0 !== 4'd0 || ov0 !== 1'b0) begin
      bad++; $display("FAIL flush_no_write: got cnt=%0d ov=%b want 0 0", cnt0, ov0); end
    for (int i = 0; i < 5; i++) step(1, 0, 16'h0D00 + 16'(i));
    step(0, 1, 16'h0);
    step(1, 1, 16'hBEEF, 0, 1);
    total++; if (cnt0 !== 4'd0 || e0 !== 1'b1 || dout0 !== 16'h0 || ov0 !== 1'b0 || un0 !== 1'b0) begin
      bad++; $display("FAIL reset_mid: got cnt=%0d e=%b dout=%h ov=%b un=%b want 0 1 0000 0 0",
                      cnt0, e0, dout0, ov0, un0); end
  endtask

  initial begin
    #2;
    test_reset();
    test_fill();
    test_drain();
    test_pass_through();
    test_random();
    test_fwft();
    test_flush_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
